// File: rtl/mem_access_unit_pkg.sv
// Shared bundle types for the memory access unit and its data bus.
package mem_access_unit_pkg;

  localparam int MAU_TIMEOUT = 255;

  typedef struct packed {
    logic        load;
    logic        store;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dbus_req_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] rdata;
  } dbus_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } mau_state_t;

endpackage

// File: rtl/micro_ops.sv
// Micro-op encoding shared by the execute-stage units.
package micro_ops;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_LB,
    OP_LBU,
    OP_LH,
    OP_LHU,
    OP_LW,
    OP_FLWS,
    OP_SB,
    OP_SH,
    OP_SW
  } op_t;

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// Picks the addressed byte/half out of a bus word and extends it for the load op.
module load_aligner
  import micro_ops::*;
(
  input  op_t         op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (op)
      OP_LB:          data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:         data = {24'h0, byte_sel};
      OP_LH:          data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:         data = {16'h0, half_sel};
      OP_LW, OP_FLWS: data = rdata;
      default:        data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store sequencer between the execute stage and the data bus.
//   state   | meaning
//   IDLE    | waiting for a load/store from execute
//   REQ     | bus request held stable until ack or timeout
//   RESP    | one-cycle response to execute (suppressed if flushed)
module mem_access_unit
  import micro_ops::*;
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MAU_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  op_t         op,
  input  mem_req_t    mem_req,
  output logic        mau_busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic        dbus_err,
  input  logic [31:0] dbus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  mau_state_t  state, state_nxt;
  logic [CW-1:0] cnt;
  op_t         op_q;
  logic [31:0] addr_q, wdata_q, rdata_q, aligned;
  logic [3:0]  be_q;
  logic        we_q, fault_q, flushed_q;
  logic        accept, timeout;
  dbus_req_t   bus_out;
  dbus_rsp_t   bus_rsp;

  assign bus_rsp = {dbus_ack, dbus_err, dbus_rdata};
  assign accept  = (state == ST_IDLE) && (mem_req.load || mem_req.store) && !flush;
  // Fires on the last allowed REQ cycle so RESP lands TIMEOUT_CYCLES+1 after accept.
  assign timeout = (cnt >= CW'(TIMEOUT_CYCLES - 1));

  load_aligner u_load_aligner (
    .op      (op_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (bus_rsp.rdata),
    .data    (aligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_REQ;
      ST_REQ:  if (bus_rsp.ack || timeout) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_q      <= OP_NOP;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      flushed_q <= 1'b0;
    end else if (accept) begin
      cnt       <= '0;
      op_q      <= op;
      addr_q    <= mem_req.addr;
      be_q      <= mem_req.mask;
      wdata_q   <= mem_req.wdata;
      we_q      <= mem_req.store;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      flushed_q <= 1'b0;
    end else if (state == ST_REQ) begin
      if (flush) flushed_q <= 1'b1;
      if (bus_rsp.ack) begin
        rdata_q <= we_q ? 32'h0 : aligned;
        fault_q <= bus_rsp.err;
      end else begin
        if (cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + CW'(1);
        if (timeout) begin
          rdata_q <= '0;
          fault_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus_out       = '0;
    bus_out.req   = (state == ST_REQ);
    bus_out.we    = we_q;
    bus_out.addr  = {addr_q[31:2], 2'b00};
    bus_out.be    = be_q;
    bus_out.wdata = wdata_q;
    // A flush seen in REQ or during RESP kills the response, never the bus cycle.
    resp_valid    = (state == ST_RESP) && !flushed_q && !flush;
    mau_busy      = (state == ST_REQ) || accept;
  end

  assign dbus_req   = bus_out.req;
  assign dbus_we    = bus_out.we;
  assign dbus_addr  = bus_out.addr;
  assign dbus_be    = bus_out.be;
  assign dbus_wdata = bus_out.wdata;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit (TIMEOUT_CYCLES = 8).
module tb_mem_access_unit;
  import micro_ops::*;
  import mem_access_unit_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  op_t         op = OP_NOP;
  mem_req_t    mem_req = '0;
  logic        dbus_ack = 1'b0;
  logic        dbus_err = 1'b0;
  logic [31:0] dbus_rdata = 32'h0;
  logic        mau_busy, resp_valid, resp_fault, dbus_req, dbus_we;
  logic [31:0] resp_rdata, dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          at;
  } exp_t;
  exp_t expq[$];

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .op         (op),
    .mem_req    (mem_req),
    .mau_busy   (mau_busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_be    (dbus_be),
    .dbus_wdata (dbus_wdata),
    .dbus_ack   (dbus_ack),
    .dbus_err   (dbus_err),
    .dbus_rdata (dbus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && resp_valid) begin
      if (expq.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_resp: got resp_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_fault", {31'h0, resp_fault}, {31'h0, e.fault});
        check("resp_cycle", cyc, e.at);
        check("busy_in_resp", {31'h0, mau_busy}, 32'h0);
      end
    end
  end

  // ack_dly < 0 means no ack (timeout); flush_at < 0 means no flush.
  task automatic do_access(input op_t o, input logic st, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] wdata,
                           input int ack_dly, input logic [31:0] rdata, input logic err,
                           input int flush_at, input logic [31:0] exp_rdata,
                           input logic exp_fault, input bit exp_resp);
    int n;
    int off;
    bit ack_now;
    op            = o;
    mem_req.load  = !st;
    mem_req.store = st;
    mem_req.addr  = addr;
    mem_req.mask  = mask;
    mem_req.wdata = wdata;
    n = cyc;
    #1;
    check("busy_on_accept", {31'h0, mau_busy}, 32'h1);
    off = (ack_dly < 0) ? TMO + 1 : ack_dly + 2;
    if (exp_resp) expq.push_back('{exp_rdata, exp_fault, n + off});
    @(posedge clk); #1;
    for (int k = 0; k < TMO; k++) begin
      ack_now = (k == ack_dly);
      check("dbus_req", {31'h0, dbus_req}, 32'h1);
      check("dbus_addr", dbus_addr, addr & 32'hFFFF_FFFC);
      check("dbus_be", {28'h0, dbus_be}, {28'h0, mask});
      check("dbus_wdata", dbus_wdata, wdata);
      check("dbus_we", {31'h0, dbus_we}, {31'h0, st});
      check("busy_in_req", {31'h0, mau_busy}, 32'h1);
      flush = (k == flush_at);
      if (ack_now) begin
        mem_req    = '0;
        dbus_ack   = 1'b1;
        dbus_err   = err;
        dbus_rdata = rdata;
      end else begin
        op            = OP_LB;
        mem_req.load  = 1'b1;
        mem_req.store = 1'b0;
        mem_req.addr  = 32'hFFFF_FFFC;
        mem_req.mask  = 4'h0;
        mem_req.wdata = 32'h0BAD_0BAD;
      end
      @(posedge clk); #1;
      dbus_ack   = 1'b0;
      dbus_err   = 1'b0;
      dbus_rdata = 32'h5A5A_5A5A;
      flush      = 1'b0;
      if (ack_now) break;
    end
    mem_req = '0;
    check("dbus_req_released", {31'h0, dbus_req}, 32'h0);
    @(posedge clk); #1;
    check("idle_busy", {31'h0, mau_busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dbus_req", {31'h0, dbus_req}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_fault", {31'h0, resp_fault}, 32'h0);
    check("rst_busy", {31'h0, mau_busy}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_dbus_addr", dbus_addr, 32'h0);
    check("rst_dbus_be", {28'h0, dbus_be}, 32'h0);
    check("rst_dbus_wdata", dbus_wdata, 32'h0);
    check("rst_dbus_we", {31'h0, dbus_we}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // stray ack while idle must not produce a response
    dbus_ack = 1'b1;
    @(posedge clk); #1;
    dbus_ack = 1'b0;

    do_access(OP_LB,   1'b0, 32'h0000_1003, 4'b1000, 32'h0, 0, 32'h80FF_FF00, 1'b0, -1, 32'hFFFF_FF80, 1'b0, 1);
    do_access(OP_LHU,  1'b0, 32'h0000_2002, 4'b1100, 32'h0, 1, 32'hBEEF_1234, 1'b0, -1, 32'h0000_BEEF, 1'b0, 1);
    do_access(OP_SW,   1'b1, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 5, 32'h1111_1111, 1'b0, -1, 32'h0, 1'b0, 1);
    do_access(OP_LW,   1'b0, 32'h0000_4000, 4'b1111, 32'h0, -1, 32'h0, 1'b0, -1, 32'h0, 1'b1, 1);
    do_access(OP_LW,   1'b0, 32'h0000_4100, 4'b1111, 32'h0, 3, 32'h7777_7777, 1'b0, 0, 32'h0, 1'b0, 0);
    do_access(OP_LH,   1'b0, 32'h0000_0000, 4'b0011, 32'h0, 0, 32'h1234_8001, 1'b0, -1, 32'hFFFF_8001, 1'b0, 1);
    do_access(OP_LW,   1'b0, 32'h0000_5004, 4'b1111, 32'h0, 2, 32'hCAFE_F00D, 1'b1, -1, 32'hCAFE_F00D, 1'b1, 1);
    do_access(OP_LB,   1'b0, 32'h0000_1001, 4'b0010, 32'h0, 0, 32'h0000_7F00, 1'b0, -1, 32'h0000_007F, 1'b0, 1);
    do_access(OP_FLWS, 1'b0, 32'h0000_6006, 4'b1111, 32'h0, 1, 32'h3F80_0000, 1'b0, -1, 32'h3F80_0000, 1'b0, 1);

    // reset in the middle of a bus request
    op            = OP_LW;
    mem_req.load  = 1'b1;
    mem_req.addr  = 32'h0000_7000;
    mem_req.mask  = 4'hF;
    @(posedge clk); #1;
    mem_req = '0;
    check("pre_rst_dbus_req", {31'h0, dbus_req}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_dbus_req", {31'h0, dbus_req}, 32'h0);
    check("midrst_busy", {31'h0, mau_busy}, 32'h0);
    check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    dbus_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_access(OP_LBU, 1'b0, 32'h0000_5001, 4'b0010, 32'h0, 0, 32'h1234_80FF, 1'b0, -1, 32'h0000_0080, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("pending_responses", expq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
